// File: rtl/fmadd_mantissa_adder_seq.sv
// Multi-cycle mantissa adder for the fused multiply-add datapath: adds (or subtracts)
// two aligned mantissas one CHUNK slice per cycle and re-negates a negative difference.
module fmadd_mantissa_adder_seq #(
   parameter int MAN   = 22,
   parameter int CHUNK = 12
) (
   input  logic                 clk,
   input  logic                 rst_l,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [2*MAN+3:0]     mant_a,
   input  logic [2*MAN+3:0]     mant_b,
   input  logic                 eff_sub,
   input  logic                 exp_diff_check,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*MAN+3:0]     out_mant,
   output logic                 out_carry,
   output logic                 out_zero
);

   localparam int W  = 2*MAN + 4;
   localparam int N  = W / CHUNK;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE, ADD, NEG, DONE} state_t;

   state_t          state_reg;
   logic [W-1:0]    a_reg;
   logic [W-1:0]    b_reg;
   logic [W-1:0]    sum_reg;
   logic            carry_reg;
   logic            sub_reg;
   logic            edc_reg;
   logic [CW-1:0]   cnt_reg;
   logic            in_ready_reg;
   logic            out_valid_reg;
   logic            out_carry_reg;
   logic            out_zero_reg;

   int              off;
   logic [CHUNK-1:0] op_x;
   logic [CHUNK-1:0] op_y;
   logic [CHUNK:0]   slice_full;
   logic [W-1:0]     sum_merged;
   logic             last_slice;

   // One shared slice adder: ADD sums A and B', NEG sums ~sum with zero (carry-in supplies the +1).
   always_comb begin
      off        = int'(cnt_reg) * CHUNK;
      op_x       = '0;
      op_y       = '0;
      if (state_reg == NEG) begin
         op_x = ~sum_reg[off +: CHUNK];
      end else begin
         op_x = a_reg[off +: CHUNK];
         op_y = b_reg[off +: CHUNK];
      end
      slice_full = {1'b0, op_x} + {1'b0, op_y} + {{CHUNK{1'b0}}, carry_reg};
      sum_merged = sum_reg;
      sum_merged[off +: CHUNK] = slice_full[CHUNK-1:0];
      last_slice = (cnt_reg == CW'(N-1));
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         state_reg     <= IDLE;
         a_reg         <= '0;
         b_reg         <= '0;
         sum_reg       <= '0;
         carry_reg     <= 1'b0;
         sub_reg       <= 1'b0;
         edc_reg       <= 1'b0;
         cnt_reg       <= '0;
         in_ready_reg  <= 1'b1;
         out_valid_reg <= 1'b0;
         out_carry_reg <= 1'b0;
         out_zero_reg  <= 1'b1;
      end else begin
         case (state_reg)
            IDLE: begin
               if (in_valid) begin
                  a_reg        <= mant_a;
                  b_reg        <= eff_sub ? ~mant_b : mant_b;
                  sub_reg      <= eff_sub;
                  edc_reg      <= exp_diff_check;
                  carry_reg    <= eff_sub & ~exp_diff_check;
                  cnt_reg      <= '0;
                  in_ready_reg <= 1'b0;
                  state_reg    <= ADD;
               end
            end
            ADD: begin
               sum_reg <= sum_merged;
               if (last_slice) begin
                  cnt_reg       <= '0;
                  out_carry_reg <= slice_full[CHUNK];
                  // No carry out of a subtraction means B > A: the sum is negative and must be re-negated.
                  if (sub_reg && !slice_full[CHUNK]) begin
                     carry_reg <= ~edc_reg;
                     state_reg <= NEG;
                  end else begin
                     carry_reg     <= 1'b0;
                     out_zero_reg  <= (sum_merged == '0);
                     out_valid_reg <= 1'b1;
                     state_reg     <= DONE;
                  end
               end else begin
                  cnt_reg   <= cnt_reg + CW'(1);
                  carry_reg <= slice_full[CHUNK];
               end
            end
            NEG: begin
               sum_reg <= sum_merged;
               if (last_slice) begin
                  cnt_reg       <= '0;
                  carry_reg     <= 1'b0;
                  out_zero_reg  <= (sum_merged == '0);
                  out_valid_reg <= 1'b1;
                  state_reg     <= DONE;
               end else begin
                  cnt_reg   <= cnt_reg + CW'(1);
                  carry_reg <= slice_full[CHUNK];
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_reg <= 1'b0;
                  in_ready_reg  <= 1'b1;
                  state_reg     <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign in_ready  = in_ready_reg;
   assign out_valid = out_valid_reg;
   assign out_mant  = sum_reg;
   assign out_carry = out_carry_reg;
   assign out_zero  = out_zero_reg;

endmodule

// File: doc/fmadd_mantissa_adder_seq.md
FMADD_MANTISSA_ADDER_SEQ -- requirements
Module: fmadd_mantissa_adder_seq

Interface
REQ-001 Parameter MAN, default 22, mantissa field width; datapath width W SHALL be 2*MAN+4 (48 at default).
REQ-002 Parameter CHUNK, default 12, slice width added per cycle; W SHALL be an integer multiple of CHUNK (N = W/CHUNK slices, 4 at default).
REQ-003 Clock and reset are fixed: one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_l  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  operand set present.
REQ-007 in_ready  output  1  block can accept operands.
REQ-008 mant_a  input  W  operand A (larger-magnitude aligned mantissa).
REQ-009 mant_b  input  W  operand B (aligned mantissa).
REQ-010 eff_sub  input  1  1 = effective subtraction.
REQ-011 exp_diff_check  input  1  0 = add +1 during two's-complement steps; 1 = plain one's complement.
REQ-012 out_valid  output  1  result held and valid.
REQ-013 out_ready  input  1  consumer accepts result.
REQ-014 out_mant  output  W  result magnitude.
REQ-015 out_carry  output  1  carry out of the main addition.
REQ-016 out_zero  output  1  out_mant equals zero.

Function
REQ-017 Operands SHALL be captured into internal registers on the cycle in_valid and in_ready are both 1; in_ready SHALL be 1 only in IDLE.
REQ-018 States SHALL be IDLE, ADD, NEG, DONE; IDLE->ADD on accept; ADD->NEG after slice N-1 if eff_sub=1 and final carry=0; ADD->DONE after slice N-1 otherwise; NEG->DONE after slice N-1; DONE->IDLE when out_ready=1.
REQ-019 Term B' SHALL be ~mant_b when eff_sub=1, mant_b otherwise; carry-in to slice 0 in ADD SHALL be (eff_sub & ~exp_diff_check).
REQ-020 ADD SHALL process one CHUNK slice per cycle, LSB slice first, using a 1-bit carry register passed between slices; slice i occupies bits [i*CHUNK +: CHUNK].
REQ-021 Final ADD carry SHALL be the carry out of bit W-1 and SHALL be registered as out_carry.
REQ-022 NEG SHALL replace the sum with ~sum + (~exp_diff_check), one slice per cycle LSB first, carry-in to slice 0 = ~exp_diff_check, carry out of bit W-1 discarded.
REQ-023 Result SHALL be bit-identical to the single-cycle form: S = A + B' + cin (mod 2^W); out = (eff_sub & ~carry) ? (~S + ~exp_diff_check) mod 2^W : S.
REQ-024 Latency accept->out_valid SHALL be N+1 cycles without NEG and 2N+1 cycles with NEG.
REQ-025 out_valid SHALL be 1 exactly in DONE; out_mant, out_carry, out_zero SHALL stay stable while out_valid=1 and out_ready=0.
REQ-026 Handshake completes on the cycle out_valid & out_ready; a new operand SHALL be accepted no earlier than the following cycle (no bypass, throughput one result per N+2 or 2N+2 cycles).
REQ-027 in_valid while busy SHALL be ignored; the operand is not captured and in_ready stays 0.
REQ-028 out_zero SHALL be computed from the final out_mant, not from intermediate slices.
REQ-029 CHUNK = W SHALL be legal and give latency 2 (add) / 3 (add+neg).

Reset
REQ-030 On rst_l=0, asynchronously: state=IDLE, in_ready=1 after deassertion, out_valid=0, out_mant=0, out_carry=0, out_zero=1, slice counter=0, carry register=0.
REQ-031 Reset asserted mid-ADD or mid-NEG SHALL abort the operation with no output handshake; the first operation after release SHALL behave as if none preceded it.

Verification
REQ-032 Add: MAN=22, CHUNK=12, A=0x000000000003, B=0x000000000005, eff_sub=0 -> after 5 cycles out_mant=0x000000000008, carry=0, zero=0.
REQ-033 Sub, A>B: A=0x000000000010, B=0x000000000003, eff_sub=1, exp_diff_check=0 -> out_mant=0x00000000000D, carry=1, latency 5.
REQ-034 Sub, A<B: A=0x000000000003, B=0x000000000010, eff_sub=1, exp_diff_check=0 -> NEG path, out_mant=0x00000000000D, carry=0, latency 9.
REQ-035 Equal sub: A=B=0x800000000000, eff_sub=1, exp_diff_check=0 -> out_mant=0, carry=1, zero=1; add overflow A=B=0x800000000000, eff_sub=0 -> out_mant=0, carry=1.
REQ-036 Backpressure/reset: hold out_ready=0 10 cycles -> outputs stable, in_ready=0, extra in_valid ignored; assert rst_l=0 in ADD slice 2 -> out_valid=0 immediately, reset values per REQ-030.
REQ-037 Random: 10k random A, B, eff_sub, exp_diff_check, random out_ready stalls, CHUNK in {1,12,48} -> match REQ-023 model.
